// File: rtl/layer_row_sequencer.sv
// rtl/layer_row_sequencer.sv - row/quadrant/layer strobe sequencer with column-beat handshake
// Walks LAYERS x 2 quadrants x ROWS rows x COLS beats, pulsing one row strobe per completed row.
module layer_row_sequencer #(
  parameter int ROWS    = 6,
  parameter int COLS    = 8,
  parameter int COL_W   = 3,
  parameter int LAYERS  = 4,
  parameter int LAYER_W = 2
) (
  input  logic               clock,
  input  logic               clear,
  input  logic               start,
  input  logic               beat_ready,
  output logic               beat_valid,
  output logic [COL_W-1:0]   col_index,
  output logic [3:0]         row_index,
  output logic               quadrant_msb,
  output logic               row_en,
  output logic               new_row,
  output logic               new_quadrant_row,
  output logic               new_layer,
  output logic [LAYER_W-1:0] layer_index,
  output logic               busy,
  output logic               done
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ISSUE   = 2'd1,
    S_ADVANCE = 2'd2,
    S_FINISH  = 2'd3
  } state_t;

  localparam logic [COL_W-1:0]   COL_LAST   = COL_W'(COLS - 1);
  localparam logic [3:0]         ROW_LAST   = 4'(ROWS - 1);
  localparam logic [LAYER_W-1:0] LAYER_LAST = LAYER_W'(LAYERS - 1);

  state_t               state_q, state_d;
  logic [COL_W-1:0]     col_q, col_d;
  logic [3:0]           row_q, row_d;
  logic                 quad_q, quad_d;
  logic [LAYER_W-1:0]   layer_q, layer_d;

  always_ff @(posedge clock) begin
    if (clear) begin
      state_q <= S_IDLE;
      col_q   <= '0;
      row_q   <= '0;
      quad_q  <= 1'b0;
      layer_q <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      quad_q  <= quad_d;
      layer_q <= layer_d;
    end
  end

  always_comb begin
    state_d          = state_q;
    col_d            = col_q;
    row_d            = row_q;
    quad_d           = quad_q;
    layer_d          = layer_q;
    beat_valid       = 1'b0;
    new_row          = 1'b0;
    new_quadrant_row = 1'b0;
    new_layer        = 1'b0;
    busy             = 1'b0;
    done             = 1'b0;

    case (state_q)
      S_IDLE: begin
        col_d   = '0;
        row_d   = '0;
        quad_d  = 1'b0;
        layer_d = '0;
        if (start) begin
          state_d = S_ISSUE;
        end
      end

      S_ISSUE: begin
        busy       = 1'b1;
        beat_valid = 1'b1;
        if (beat_ready) begin
          if (col_q == COL_LAST) begin
            col_d   = '0;
            state_d = S_ADVANCE;
          end else begin
            col_d = col_q + 1'b1;
          end
        end
      end

      S_ADVANCE: begin
        busy    = 1'b1;
        state_d = S_ISSUE;
        if (row_q != ROW_LAST) begin
          new_row = 1'b1;
          row_d   = row_q + 4'd1;
        end else if (!quad_q) begin
          new_quadrant_row = 1'b1;
          row_d            = '0;
          quad_d           = 1'b1;
        end else begin
          new_quadrant_row = 1'b1;
          new_layer        = 1'b1;
          row_d            = '0;
          quad_d           = 1'b0;
          // Final layer clears instead of incrementing so layer_index never wraps.
          if (layer_q == LAYER_LAST) begin
            layer_d = '0;
            state_d = S_FINISH;
          end else begin
            layer_d = layer_q + 1'b1;
          end
        end
      end

      S_FINISH: begin
        done    = 1'b1;
        col_d   = '0;
        row_d   = '0;
        quad_d  = 1'b0;
        layer_d = '0;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign col_index    = col_q;
  assign row_index    = quad_q ? (4'(ROWS) + row_q) : row_q;
  assign quadrant_msb = quad_q;
  assign layer_index  = layer_q;
  assign row_en       = busy;

endmodule
